// File: rtl/softmax_pkg.sv
// Shared constants and helpers for the softmax controller: FSM encodings,
// sum-width sizing and the flattened-vector slice mapping.
package softmax_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MAX  = 3'd1;
    localparam logic [2:0] ST_EXP  = 3'd2;
    localparam logic [2:0] ST_DIV  = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;

    // Wide enough to hold n * (2^exp_width - 1) without overflow.
    function automatic int sum_width(input int exp_width, input int n);
        return exp_width + $clog2(n);
    endfunction

    // Element 0 lives in the MSB slice, element n-1 in the LSB slice.
    function automatic int slice_lsb(input int idx, input int n, input int dw);
        return (n - 1 - idx) * dw;
    endfunction

endpackage

// File: rtl/softmax_req_seq.sv
// One-outstanding request/response sequencer: walks indices 0..N-1, holds
// valid until accepted, and accepts exactly one response per request.
module softmax_req_seq #(
    parameter  int N    = 5,
    localparam int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_ready,
    input  logic            i_resp_valid,
    output logic            o_valid,
    output logic [IDXW-1:0] o_idx,
    output logic            o_capture,
    output logic            o_last
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    logic            r_valid;
    logic            r_pending;
    logic [IDXW-1:0] r_idx;

    // Responses are only honoured after the accept cycle of the current request.
    assign o_capture = r_pending & i_resp_valid;
    assign o_last    = o_capture & (r_idx == LAST_IDX);
    assign o_valid   = r_valid;
    assign o_idx     = r_idx;

    // Request valid/pending handshake and index advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pending <= 1'b0;
            r_idx     <= '0;
        end else if (i_start) begin
            r_valid   <= 1'b1;
            r_pending <= 1'b0;
            r_idx     <= '0;
        end else if (r_valid && i_ready) begin
            r_valid   <= 1'b0;
            r_pending <= 1'b1;
        end else if (o_capture) begin
            r_pending <= 1'b0;
            if (r_idx != LAST_IDX) begin
                r_idx   <= r_idx + IDXW'(1);
                r_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/softmax_ctrl.sv
// Softmax sequencer for one neighbourhood: max search, exp pass with running
// sum, divide pass, then hands the alpha vector downstream.
module softmax_ctrl
    import softmax_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int NUM_OF_NODES = 5,
    parameter  int EXP_WIDTH    = 16,
    localparam int SUM_WIDTH    = sum_width(EXP_WIDTH, NUM_OF_NODES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               sm_valid_i,
    output logic                               sm_ready_o,
    input  logic [NUM_OF_NODES*DATA_WIDTH-1:0] coef_i,
    output logic                               exp_valid_o,
    input  logic                               exp_ready_i,
    output logic [DATA_WIDTH-1:0]              exp_x_o,
    input  logic                               exp_resp_valid_i,
    input  logic [EXP_WIDTH-1:0]               exp_y_i,
    output logic                               div_valid_o,
    input  logic                               div_ready_i,
    output logic [SUM_WIDTH-1:0]               div_num_o,
    output logic [SUM_WIDTH-1:0]               div_den_o,
    input  logic                               div_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]              div_q_i,
    output logic                               alpha_valid_o,
    input  logic                               alpha_ready_i,
    output logic [NUM_OF_NODES*DATA_WIDTH-1:0] alpha_o,
    output logic                               busy_o
);

    localparam int N    = NUM_OF_NODES;
    localparam int DW   = DATA_WIDTH;
    localparam int IDXW = $clog2(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    logic [2:0]            r_state;
    logic signed [DW-1:0]  r_coef [N];
    logic signed [DW-1:0]  r_max;
    logic [IDXW-1:0]       r_k;
    logic [EXP_WIDTH-1:0]  r_exp [N];
    logic [SUM_WIDTH-1:0]  r_sum;
    logic [DW-1:0]         r_alpha [N];

    logic signed [DW-1:0]  w_coef_in [N];
    logic [IDXW-1:0]       w_exp_idx;
    logic [IDXW-1:0]       w_div_idx;
    logic                  w_exp_cap;
    logic                  w_exp_last;
    logic                  w_div_cap;
    logic                  w_div_last;
    logic                  w_exp_start;
    logic                  w_div_start;
    logic [SUM_WIDTH-1:0]  w_sum_next;
    logic signed [DW:0]    w_diff;

    // coef <= max, so only the negative side can overflow DW bits.
    function automatic logic [DW-1:0] sat_neg(input logic signed [DW:0] d);
        if (d[DW] && !d[DW-1]) begin
            return {1'b1, {(DW-1){1'b0}}};
        end else begin
            return d[DW-1:0];
        end
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign w_coef_in[i] = coef_i[slice_lsb(i, N, DW) +: DW];
        assign alpha_o[slice_lsb(i, N, DW) +: DW] = r_alpha[i];
    end

    assign w_diff      = {r_coef[w_exp_idx][DW-1], r_coef[w_exp_idx]} - {r_max[DW-1], r_max};
    assign exp_x_o     = sat_neg(w_diff);
    assign div_num_o   = SUM_WIDTH'(r_exp[w_div_idx]);
    assign div_den_o   = r_sum;
    assign w_sum_next  = r_sum + SUM_WIDTH'(exp_y_i);
    assign w_exp_start = (r_state == ST_MAX) && (r_k == LAST_IDX);
    assign w_div_start = w_exp_last && (w_sum_next != {SUM_WIDTH{1'b0}});

    assign sm_ready_o    = (r_state == ST_IDLE);
    assign busy_o        = (r_state != ST_IDLE);
    assign alpha_valid_o = (r_state == ST_OUT);

    softmax_req_seq #(.N(N)) u_exp_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (w_exp_start),
        .i_ready      (exp_ready_i),
        .i_resp_valid (exp_resp_valid_i),
        .o_valid      (exp_valid_o),
        .o_idx        (w_exp_idx),
        .o_capture    (w_exp_cap),
        .o_last       (w_exp_last)
    );

    softmax_req_seq #(.N(N)) u_div_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (w_div_start),
        .i_ready      (div_ready_i),
        .i_resp_valid (div_resp_valid_i),
        .o_valid      (div_valid_o),
        .o_idx        (w_div_idx),
        .o_capture    (w_div_cap),
        .o_last       (w_div_last)
    );

    // Main phase FSM plus the coefficient, exp, sum and alpha buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_coef  <= '{default: '0};
            r_max   <= '0;
            r_k     <= '0;
            r_exp   <= '{default: '0};
            r_sum   <= '0;
            r_alpha <= '{default: '0};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sm_valid_i) begin
                        r_coef  <= w_coef_in;
                        r_max   <= w_coef_in[0];
                        r_k     <= '0;
                        r_state <= ST_MAX;
                    end
                end
                ST_MAX: begin
                    if (r_coef[r_k] > r_max) begin
                        r_max <= r_coef[r_k];
                    end
                    if (r_k == LAST_IDX) begin
                        r_sum   <= '0;
                        r_state <= ST_EXP;
                    end else begin
                        r_k <= r_k + IDXW'(1);
                    end
                end
                ST_EXP: begin
                    if (w_exp_cap) begin
                        r_exp[w_exp_idx] <= exp_y_i;
                        r_sum            <= w_sum_next;
                        if (w_exp_last) begin
                            if (w_sum_next == {SUM_WIDTH{1'b0}}) begin
                                r_alpha <= '{default: '0};
                                r_state <= ST_OUT;
                            end else begin
                                r_state <= ST_DIV;
                            end
                        end
                    end
                end
                ST_DIV: begin
                    if (w_div_cap) begin
                        r_alpha[w_div_idx] <= div_q_i;
                        if (w_div_last) begin
                            r_state <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (alpha_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_ctrl.sv
// Self-checking bench for softmax_ctrl: behavioural exp/div units, a reference
// softmax model feeding scoreboard queues, a vector table and corner sequences.
module tb_softmax_ctrl;

    localparam int DW = 8;
    localparam int N  = 5;
    localparam int EW = 16;
    localparam int SW = 19;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sm_valid_i;
    logic          sm_ready_o;
    logic [N*DW-1:0] coef_i;
    logic          exp_valid_o;
    logic          exp_ready_i;
    logic [DW-1:0] exp_x_o;
    logic          exp_resp_valid_i;
    logic [EW-1:0] exp_y_i;
    logic          div_valid_o;
    logic          div_ready_i;
    logic [SW-1:0] div_num_o;
    logic [SW-1:0] div_den_o;
    logic          div_resp_valid_i;
    logic [DW-1:0] div_q_i;
    logic          alpha_valid_o;
    logic          alpha_ready_i;
    logic [N*DW-1:0] alpha_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;
    int g_stall  = 0;
    int g_delay  = 1;
    bit g_zero   = 1'b0;

    int              exp_q   [$];
    logic [SW-1:0]   num_q   [$];
    logic [SW-1:0]   den_q   [$];
    logic [N*DW-1:0] alpha_q [$];

    typedef struct {
        logic [N*DW-1:0] coef;
        int              stall;
        int              delay;
        bit              zero;
        int              lat;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    softmax_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sm_valid_i       (sm_valid_i),
        .sm_ready_o       (sm_ready_o),
        .coef_i           (coef_i),
        .exp_valid_o      (exp_valid_o),
        .exp_ready_i      (exp_ready_i),
        .exp_x_o          (exp_x_o),
        .exp_resp_valid_i (exp_resp_valid_i),
        .exp_y_i          (exp_y_i),
        .div_valid_o      (div_valid_o),
        .div_ready_i      (div_ready_i),
        .div_num_o        (div_num_o),
        .div_den_o        (div_den_o),
        .div_resp_valid_i (div_resp_valid_i),
        .div_q_i          (div_q_i),
        .alpha_valid_o    (alpha_valid_o),
        .alpha_ready_i    (alpha_ready_i),
        .alpha_o          (alpha_o),
        .busy_o           (busy_o)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int exp_model(input int x);
        if (x < -8) return 0;
        return 1 << (8 + x);
    endfunction

    function automatic logic [N*DW-1:0] mk(input int a0, input int a1, input int a2,
                                            input int a3, input int a4);
        return {8'(a0), 8'(a1), 8'(a2), 8'(a3), 8'(a4)};
    endfunction

    // Reference softmax: pushes expected exp args, div operands and alphas.
    task automatic push_expect(input logic [N*DW-1:0] c, input bit zero);
        int v [N];
        int y [N];
        int mx;
        int d;
        int s;
        logic [N*DW-1:0] a;
        for (int i = 0; i < N; i++) v[i] = int'($signed(c[(N-1-i)*DW +: DW]));
        mx = v[0];
        for (int i = 1; i < N; i++) if (v[i] > mx) mx = v[i];
        s = 0;
        for (int i = 0; i < N; i++) begin
            d = v[i] - mx;
            if (d < -128) d = -128;
            exp_q.push_back(d);
            y[i] = zero ? 0 : exp_model(d);
            s += y[i];
        end
        a = '0;
        if (s != 0) begin
            for (int i = 0; i < N; i++) begin
                num_q.push_back(SW'(y[i]));
                den_q.push_back(SW'(s));
                a[(N-1-i)*DW +: DW] = 8'((y[i] * 255) / s);
            end
        end
        alpha_q.push_back(a);
    endtask

    // Behavioural exp unit: optional ready stall, response after g_delay cycles.
    initial begin : exp_unit
        int ph;
        int cnt;
        int hx;
        ph = 0; cnt = 0; hx = 0;
        exp_ready_i = 1'b0; exp_resp_valid_i = 1'b0; exp_y_i = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_ready_i = 1'b0; exp_resp_valid_i = 1'b0; ph = 0;
            end else begin
                if (ph == 3) begin exp_resp_valid_i = 1'b0; ph = 0; end
                if (ph == 0) begin
                    if (exp_valid_o) begin
                        hx = int'($signed(exp_x_o));
                        if (g_stall == 0) ph = 4; else begin cnt = g_stall; ph = 1; end
                    end
                end else if (ph == 1) begin
                    check("exp_stall_valid", 64'(exp_valid_o), 64'd1);
                    check("exp_stall_x", int'($signed(exp_x_o)), hx);
                    cnt--;
                    if (cnt == 0) ph = 4;
                end else if (ph == 2) begin
                    exp_ready_i = 1'b0;
                    check("exp_one_outstanding", 64'(exp_valid_o), 64'd0);
                    cnt--;
                    if (cnt == 0) begin
                        exp_resp_valid_i = 1'b1;
                        exp_y_i = g_zero ? 16'd0 : 16'(exp_model(hx));
                        ph = 3;
                    end
                end
                if (ph == 4) begin
                    exp_ready_i = 1'b1;
                    if (exp_q.size() == 0) check("exp_unexpected_req", 64'd1, 64'd0);
                    else check("exp_x", hx, exp_q.pop_front());
                    cnt = g_delay; ph = 2;
                end
            end
        end
    end

    // Behavioural divider: floor(num*255/den), same stall/delay behaviour.
    initial begin : div_unit
        int ph;
        int cnt;
        logic [SW-1:0] hn;
        logic [SW-1:0] hd;
        logic [63:0]   t;
        ph = 0; cnt = 0; hn = '0; hd = '0;
        div_ready_i = 1'b0; div_resp_valid_i = 1'b0; div_q_i = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                div_ready_i = 1'b0; div_resp_valid_i = 1'b0; ph = 0;
            end else begin
                if (ph == 3) begin div_resp_valid_i = 1'b0; ph = 0; end
                if (ph == 0) begin
                    if (div_valid_o) begin
                        hn = div_num_o; hd = div_den_o;
                        if (g_stall == 0) ph = 4; else begin cnt = g_stall; ph = 1; end
                    end
                end else if (ph == 1) begin
                    check("div_stall_valid", 64'(div_valid_o), 64'd1);
                    check("div_stall_num", 64'(div_num_o), 64'(hn));
                    check("div_stall_den", 64'(div_den_o), 64'(hd));
                    cnt--;
                    if (cnt == 0) ph = 4;
                end else if (ph == 2) begin
                    div_ready_i = 1'b0;
                    check("div_one_outstanding", 64'(div_valid_o), 64'd0);
                    cnt--;
                    if (cnt == 0) begin
                        t = (hd == '0) ? 64'd0 : (64'(hn) * 64'd255) / 64'(hd);
                        div_q_i = 8'(t);
                        div_resp_valid_i = 1'b1;
                        ph = 3;
                    end
                end
                if (ph == 4) begin
                    div_ready_i = 1'b1;
                    if (num_q.size() == 0) check("div_unexpected_req", 64'd1, 64'd0);
                    else begin
                        check("div_num", 64'(hn), 64'(num_q.pop_front()));
                        check("div_den", 64'(hd), 64'(den_q.pop_front()));
                    end
                    cnt = g_delay; ph = 2;
                end
            end
        end
    end

    task automatic send(input logic [N*DW-1:0] c);
        int n;
        n = 0;
        while (!sm_ready_o && n < 3000) begin @(negedge clk); n++; end
        if (!sm_ready_o) check("sm_ready_timeout", 64'd0, 64'd1);
        sm_valid_i = 1'b1;
        coef_i     = c;
        @(negedge clk);
        sm_valid_i = 1'b0;
        check("accepted_busy", 64'(busy_o), 64'd1);
    endtask

    task automatic wait_alpha(output int cyc);
        cyc = 1;
        while (!alpha_valid_o && cyc < 3000) begin @(negedge clk); cyc++; end
        if (!alpha_valid_o) check("alpha_timeout", 64'd0, 64'd1);
    endtask

    task automatic take_alpha(input string tag, input int hold);
        logic [N*DW-1:0] e;
        if (alpha_q.size() == 0) begin
            check({tag, "_alpha_expected"}, 64'd1, 64'd0);
            e = '0;
        end else begin
            e = alpha_q.pop_front();
        end
        check({tag, "_alpha"}, 64'(alpha_o), 64'(e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_alpha"}, 64'(alpha_o), 64'(e));
            check({tag, "_hold_valid"}, 64'(alpha_valid_o), 64'd1);
            check({tag, "_hold_sm_ready"}, 64'(sm_ready_o), 64'd0);
        end
        alpha_ready_i = 1'b1;
        @(negedge clk);
        alpha_ready_i = 1'b0;
        check({tag, "_alpha_drop"}, 64'(alpha_valid_o), 64'd0);
    endtask

    task automatic run_one(input string tag, input vec_t v);
        int lat;
        g_stall = v.stall;
        g_delay = v.delay;
        g_zero  = v.zero;
        push_expect(v.coef, v.zero);
        send(v.coef);
        wait_alpha(lat);
        if (v.lat >= 0) check({tag, "_latency"}, 64'(lat), 64'(v.lat));
        take_alpha(tag, 0);
        check({tag, "_exp_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_div_drained"}, 64'(num_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sm_ready"},    64'(sm_ready_o),    64'd1);
        check({tag, "_busy"},        64'(busy_o),        64'd0);
        check({tag, "_exp_valid"},   64'(exp_valid_o),   64'd0);
        check({tag, "_div_valid"},   64'(div_valid_o),   64'd0);
        check({tag, "_alpha_valid"}, 64'(alpha_valid_o), 64'd0);
        check({tag, "_alpha"},       64'(alpha_o),       64'd0);
        check({tag, "_exp_x"},       64'(exp_x_o),       64'd0);
        check({tag, "_div_num"},     64'(div_num_o),     64'd0);
        check({tag, "_div_den"},     64'(div_den_o),     64'd0);
    endtask

    initial begin : main
        int lat;
        int n;
        rst_n = 1'b0; sm_valid_i = 1'b0; coef_i = '0; alpha_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        tbl[0] = '{coef: mk(5, 3, -2, 0, 5),          stall: 0, delay: 1, zero: 1'b0, lat: 26};
        tbl[1] = '{coef: mk(10, -3, 7, 7, 0),         stall: 3, delay: 4, zero: 1'b0, lat: -1};
        tbl[2] = '{coef: mk(127, -128, 0, -1, 100),   stall: 0, delay: 1, zero: 1'b0, lat: 26};
        tbl[3] = '{coef: mk(1, 2, 3, 4, 5),           stall: 0, delay: 1, zero: 1'b1, lat: -1};
        tbl[4] = '{coef: mk(-1, -1, -1, -1, -1),      stall: 0, delay: 1, zero: 1'b0, lat: 26};
        tbl[5] = '{coef: mk(-128, -128, -128, -128, -127), stall: 1, delay: 2, zero: 1'b0, lat: -1};

        for (int i = 0; i < 6; i++) run_one($sformatf("vec%0d", i), tbl[i]);

        // Back-to-back: downstream stalls 10 cycles while the next vector waits.
        g_stall = 0; g_delay = 1; g_zero = 1'b0;
        push_expect(mk(0, 0, -1, -2, -3), 1'b0);
        push_expect(mk(20, 10, 15, -5, 18), 1'b0);
        send(mk(0, 0, -1, -2, -3));
        wait_alpha(lat);
        sm_valid_i = 1'b1;
        coef_i     = mk(20, 10, 15, -5, 18);
        take_alpha("b2b_a", 10);
        check("b2b_ready_after_handshake", 64'(sm_ready_o), 64'd1);
        @(negedge clk);
        sm_valid_i = 1'b0;
        check("b2b_second_accepted", 64'(busy_o), 64'd1);
        wait_alpha(lat);
        check("b2b_b_latency", 64'(lat), 64'd26);
        take_alpha("b2b_b", 0);

        // Reset while an exp request is outstanding.
        g_delay = 3;
        push_expect(mk(4, 1, -9, 3, 2), 1'b0);
        send(mk(4, 1, -9, 3, 2));
        n = 0;
        while (!exp_valid_o && n < 100) begin @(negedge clk); n++; end
        check("rst_reached_exp", 64'(exp_valid_o), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete(); num_q.delete(); den_q.delete(); alpha_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_one("post_rst", '{coef: mk(2, -6, 1, 1, -20), stall: 0, delay: 1, zero: 1'b0, lat: 26});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
